arc4_decrypt: RTL and testbench



---
 rtl/arc4_decrypt.sv | 212 +++++++++++++++++++++
 tb/tb_arc4_decrypt.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/arc4_decrypt.sv
// arc4_decrypt: ARC4 decryption engine with 24-bit key and an internal 256x8 state memory.
// Latency from the edge that samples en (counted) to rdy high is 1796 + 10*L cycles.
module arc4_decrypt (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  ct_addr,
  input  logic [7:0]  ct_rddata,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata,
  output logic [7:0]  pt_wrdata,
  output logic        pt_wren
);
  typedef enum logic [1:0] {IDLE, INIT, KSA, PRGA} top_t;
  typedef enum logic [2:0] {K_RDI, K_WTI, K_RDJ, K_WTJ, K_WRI, K_WRJ} ksa_t;
  typedef enum logic [3:0] {P_LEN, P_LWT, P_PT0, P_RDI, P_WTI, P_RDJ, P_WTJ, P_WRI, P_WRJ,
                            P_RDP, P_WTP, P_XOR, P_PT} prga_t;
  top_t state_q, state_d;
  ksa_t ks_q, ks_d;
  prga_t ps_q, ps_d;
  logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d, si_q, si_d, sj_q, sj_d;
  logic [7:0] pad_q, pad_d, len_q, len_d, xor_q, xor_d;
  logic [1:0] km_q, km_d;
  logic [23:0] key_q, key_d;
  logic [7:0] s_mem [256];
  logic [7:0] s_rd_q, s_addr, s_wd, kbyte;
  logic s_we, init_done, ksa_done, prga_done, unused_pt;
  assign unused_pt = ^pt_rddata;
  assign rdy = state_q == IDLE;
  assign kbyte = km_q == 2'd0 ? key_q[23:16] : km_q == 2'd1 ? key_q[15:8] : key_q[7:0];
  assign init_done = state_q == INIT && i_q == 8'd255;
  assign ksa_done = state_q == KSA && ks_q == K_WRJ && i_q == 8'd255;
  assign prga_done = state_q == PRGA &&
                     ((ps_q == P_PT0 && len_q == 8'd0) || (ps_q == P_PT && k_q == len_q));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ks_q <= K_RDI;
      ps_q <= P_LEN;
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
      km_q <= '0;
      si_q <= '0;
      sj_q <= '0;
      pad_q <= '0;
      len_q <= '0;
      xor_q <= '0;
      key_q <= '0;
    end else begin
      state_q <= state_d;
      ks_q <= ks_d;
      ps_q <= ps_d;
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
      km_q <= km_d;
      si_q <= si_d;
      sj_q <= sj_d;
      pad_q <= pad_d;
      len_q <= len_d;
      xor_q <= xor_d;
      key_q <= key_d;
    end
  end
  always_ff @(posedge clk) begin
    if (s_we) s_mem[s_addr] <= s_wd;
    s_rd_q <= s_mem[s_addr];
  end
  always_comb begin
    state_d = state_q;
    ks_d = ks_q;
    ps_d = ps_q;
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    km_d = km_q;
    si_d = si_q;
    sj_d = sj_q;
    pad_d = pad_q;
    len_d = len_q;
    xor_d = xor_q;
    key_d = key_q;
    s_addr = i_q;
    s_wd = i_q;
    s_we = 1'b0;
    // ct address is held for the whole byte so the read overlaps the S accesses
    ct_addr = state_q == PRGA ? k_q : 8'd0;
    pt_addr = 8'd0;
    pt_wrdata = 8'd0;
    pt_wren = 1'b0;
    case (state_q)
      IDLE: if (en) begin
        state_d = INIT;
        key_d = key;
        i_d = 8'd0;
      end
      INIT: begin
        s_we = 1'b1;
        i_d = i_q + 8'd1;
        if (init_done) begin
          state_d = KSA;
          ks_d = K_RDI;
          j_d = 8'd0;
          km_d = 2'd0;
        end
      end
      KSA: case (ks_q)
        K_RDI: ks_d = K_WTI;
        K_WTI: begin
          si_d = s_rd_q;
          j_d = j_q + s_rd_q + kbyte;
          ks_d = K_RDJ;
        end
        K_RDJ: begin
          s_addr = j_q;
          ks_d = K_WTJ;
        end
        K_WTJ: begin
          sj_d = s_rd_q;
          ks_d = K_WRI;
        end
        K_WRI: begin
          s_we = 1'b1;
          s_wd = sj_q;
          ks_d = K_WRJ;
        end
        K_WRJ: begin
          s_addr = j_q;
          s_we = 1'b1;
          s_wd = si_q;
          i_d = i_q + 8'd1;
          km_d = km_q == 2'd2 ? 2'd0 : km_q + 2'd1;
          ks_d = K_RDI;
          if (ksa_done) begin
            state_d = PRGA;
            ps_d = P_LEN;
            j_d = 8'd0;
            k_d = 8'd0;
          end
        end
        default: ks_d = K_RDI;
      endcase
      default: case (ps_q)
        P_LEN: ps_d = P_LWT;
        P_LWT: begin
          len_d = ct_rddata;
          ps_d = P_PT0;
        end
        P_PT0: begin
          pt_wren = 1'b1;
          pt_wrdata = len_q;
          k_d = 8'd1;
          ps_d = P_RDI;
          if (prga_done) state_d = IDLE;
        end
        P_RDI: begin
          s_addr = i_q + 8'd1;
          i_d = i_q + 8'd1;
          ps_d = P_WTI;
        end
        P_WTI: begin
          si_d = s_rd_q;
          j_d = j_q + s_rd_q;
          ps_d = P_RDJ;
        end
        P_RDJ: begin
          s_addr = j_q;
          ps_d = P_WTJ;
        end
        P_WTJ: begin
          sj_d = s_rd_q;
          ps_d = P_WRI;
        end
        P_WRI: begin
          s_we = 1'b1;
          s_wd = sj_q;
          ps_d = P_WRJ;
        end
        P_WRJ: begin
          s_addr = j_q;
          s_we = 1'b1;
          s_wd = si_q;
          ps_d = P_RDP;
        end
        P_RDP: begin
          s_addr = si_q + sj_q;
          ps_d = P_WTP;
        end
        P_WTP: begin
          pad_d = s_rd_q;
          ps_d = P_XOR;
        end
        P_XOR: begin
          xor_d = ct_rddata ^ pad_q;
          ps_d = P_PT;
        end
        P_PT: begin
          pt_wren = 1'b1;
          pt_addr = k_q;
          pt_wrdata = xor_q;
          k_d = k_q + 8'd1;
          ps_d = P_RDI;
          if (prga_done) state_d = IDLE;
        end
        default: ps_d = P_LEN;
      endcase
    endcase
  end
endmodule

// File: tb/tb_arc4_decrypt.sv
// tb_arc4_decrypt: directed bench for arc4_decrypt with a software RC4 reference model.
`timescale 1ns/1ps
module tb_arc4_decrypt;
  localparam int BASE_LAT = 1796;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic rdy, pt_wren;
  logic [23:0] key = '0;
  logic [7:0] ct_addr, pt_addr, pt_wrdata;
  logic [7:0] ct_rddata = '0, pt_rddata = '0;
  logic [7:0] ct_mem [256];
  logic [7:0] ref_s [256];
  logic [7:0] ref_ks [256];
  logic [7:0] wr_adr [4096];
  logic [7:0] wr_dat [4096];
  int wr_cnt = 0;
  int total = 0, bad = 0;
  logic [127:0] msg = "Hello, ARC4 test";

  arc4_decrypt dut (.clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key), .ct_addr(ct_addr),
                    .ct_rddata(ct_rddata), .pt_addr(pt_addr), .pt_rddata(pt_rddata),
                    .pt_wrdata(pt_wrdata), .pt_wren(pt_wren));

  always #5 clk = ~clk;
  always @(posedge clk) ct_rddata <= ct_mem[ct_addr];
  always @(negedge clk) if (pt_wren) begin
    wr_adr[wr_cnt[11:0]] = pt_addr;
    wr_dat[wr_cnt[11:0]] = pt_wrdata;
    wr_cnt++;
  end

  task automatic ref_ksa(input logic [23:0] k);
    logic [7:0] j, t;
    j = 8'd0;
    for (int n = 0; n < 256; n++) ref_s[n] = 8'(n);
    for (int n = 0; n < 256; n++) begin
      j = j + ref_s[n] + (n % 3 == 0 ? k[23:16] : n % 3 == 1 ? k[15:8] : k[7:0]);
      t = ref_s[n]; ref_s[n] = ref_s[j]; ref_s[j] = t;
    end
  endtask

  task automatic ref_prga(input int len);
    logic [7:0] i, j, t, p;
    i = 8'd0; j = 8'd0;
    for (int n = 1; n <= len; n++) begin
      i = i + 8'd1;
      j = j + ref_s[i];
      t = ref_s[i]; ref_s[i] = ref_s[j]; ref_s[j] = t;
      p = ref_s[i] + ref_s[j];
      ref_ks[n] = ref_s[p];
    end
  endtask

  task automatic load_msg(input logic [23:0] k);
    ref_ksa(k);
    ref_prga(16);
    ct_mem[0] = 8'd16;
    for (int n = 1; n <= 16; n++) ct_mem[n] = msg[8*(16-n) +: 8] ^ ref_ks[n];
  endtask

  task automatic start(input logic [23:0] k);
    key = k; en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
  endtask

  task automatic wait_rdy(output int n);
    n = 1;
    while (!rdy && n < 10000) begin @(posedge clk); #1; n++; end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b exp=1", rdy); end
    total++; if (pt_wren !== 1'b0) begin bad++; $display("FAIL reset_wren got=%b exp=0", pt_wren); end
    total++; if ({ct_addr, pt_addr, pt_wrdata} !== 24'h0) begin
      bad++; $display("FAIL reset_addr_data got=%h exp=000000", {ct_addr, pt_addr, pt_wrdata});
    end
    total++; if ({dut.i_q, dut.j_q, dut.k_q} !== 24'h0) begin
      bad++; $display("FAIL reset_ijk got=%h exp=000000", {dut.i_q, dut.j_q, dut.k_q});
    end
  endtask

  task automatic test_idle;
    int base, moved;
    base = wr_cnt; moved = 0;
    repeat (20) begin @(posedge clk); #1; if (ct_addr !== 8'h00) moved++; end
    total++; if (moved != 0) begin bad++; $display("FAIL idle_ct_addr got=%0d changes exp=0", moved); end
    total++; if (wr_cnt != base) begin bad++; $display("FAIL idle_writes got=%0d exp=0", wr_cnt - base); end
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL idle_rdy got=%b exp=1", rdy); end
  endtask

  task automatic test_empty;
    int base, n;
    logic [11:0] idx;
    ct_mem[0] = 8'd0;
    base = wr_cnt;
    start(24'h000018);
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL empty_busy got=%b exp=0", rdy); end
    wait_rdy(n);
    total++; if (n != BASE_LAT) begin bad++; $display("FAIL empty_latency got=%0d exp=%0d", n, BASE_LAT); end
    total++; if (wr_cnt - base != 1) begin bad++; $display("FAIL empty_count got=%0d exp=1", wr_cnt - base); end
    idx = 12'(base);
    total++; if ({wr_adr[idx], wr_dat[idx]} !== 16'h0000) begin
      bad++; $display("FAIL empty_pt0 got=%h exp=0000", {wr_adr[idx], wr_dat[idx]});
    end
    @(posedge clk); #1;
    total++; if (rdy !== 1'b1 || wr_cnt - base != 1) begin
      bad++; $display("FAIL empty_after got rdy=%b writes=%0d exp rdy=1 writes=1", rdy, wr_cnt - base);
    end
  endtask

  task automatic test_init_ksa;
    int errs, n;
    ct_mem[0] = 8'd0;
    ref_ksa(24'h000000);
    start(24'h000000);
    repeat (256) @(posedge clk);
    #1 errs = 0;
    for (int m = 0; m < 256; m++) if (dut.s_mem[m] !== 8'(m)) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL init_fill got=%0d wrong exp=0", errs); end
    repeat (1536) @(posedge clk);
    #1 errs = 0;
    for (int m = 0; m < 256; m++) if (dut.s_mem[m] !== ref_s[m]) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL ksa_state got=%0d wrong exp=0", errs); end
    wait_rdy(n);
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL init_ksa_done got=%b exp=1", rdy); end
  endtask

  task automatic test_known_answer;
    int base, n;
    logic [11:0] idx;
    logic [7:0] exp;
    load_msg(24'h000018);
    base = wr_cnt;
    start(24'h000018);
    wait_rdy(n);
    total++; if (n != BASE_LAT + 160) begin bad++; $display("FAIL ka_latency got=%0d exp=%0d", n, BASE_LAT + 160); end
    total++; if (wr_cnt - base != 17) begin bad++; $display("FAIL ka_count got=%0d exp=17", wr_cnt - base); end
    for (int m = 0; m <= 16; m++) begin
      idx = 12'(base + m);
      exp = m == 0 ? 8'd16 : msg[8*(16-m) +: 8];
      total++; if (wr_adr[idx] !== 8'(m) || wr_dat[idx] !== exp) begin
        bad++; $display("FAIL ka_byte%0d got addr=%0d data=%h exp addr=%0d data=%h", m, wr_adr[idx], wr_dat[idx], m, exp);
      end
    end
  endtask

  task automatic test_busy_restart;
    int base, n, errs;
    logic [11:0] idx;
    load_msg(24'h000018);
    base = wr_cnt;
    start(24'h000018);
    repeat (400) @(posedge clk);
    #1 key = 24'hABCDEF; en = 1'b1;
    @(posedge clk); #1 en = 1'b0; key = 24'h000000;
    wait_rdy(n);
    errs = 0;
    for (int m = 0; m <= 16; m++) begin
      idx = 12'(base + m);
      if (wr_dat[idx] !== (m == 0 ? 8'd16 : msg[8*(16-m) +: 8])) errs++;
    end
    total++; if (wr_cnt - base != 17 || errs != 0) begin
      bad++; $display("FAIL busy_en got writes=%0d bad_bytes=%0d exp writes=17 bad_bytes=0", wr_cnt - base, errs);
    end
    base = wr_cnt;
    start(24'h000018);
    repeat (1820) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL abort_rdy got=%b exp=1", rdy); end
    total++; if (wr_cnt - base != 3) begin bad++; $display("FAIL abort_prior got=%0d exp=3", wr_cnt - base); end
    base = wr_cnt;
    repeat (50) @(posedge clk);
    #1;
    total++; if (wr_cnt != base) begin bad++; $display("FAIL abort_quiet got=%0d exp=0", wr_cnt - base); end
    start(24'h000018);
    wait_rdy(n);
    errs = 0;
    for (int m = 0; m <= 16; m++) begin
      idx = 12'(base + m);
      if (wr_adr[idx] !== 8'(m) || wr_dat[idx] !== (m == 0 ? 8'd16 : msg[8*(16-m) +: 8])) errs++;
    end
    total++; if (n != BASE_LAT + 160 || wr_cnt - base != 17 || errs != 0) begin
      bad++; $display("FAIL restart got lat=%0d writes=%0d bad_bytes=%0d exp lat=%0d writes=17 bad_bytes=0",
                      n, wr_cnt - base, errs, BASE_LAT + 160);
    end
  endtask

  task automatic test_max_length;
    int base, n, aerr, derr;
    logic [11:0] idx;
    logic [23:0] k;
    logic [7:0] exp;
    k = 24'($urandom);
    ct_mem[0] = 8'd255;
    for (int m = 1; m < 256; m++) ct_mem[m] = 8'($urandom_range(0, 255));
    ref_ksa(k);
    ref_prga(255);
    base = wr_cnt;
    start(k);
    wait_rdy(n);
    total++; if (n != BASE_LAT + 2550) begin bad++; $display("FAIL max_latency got=%0d exp=%0d", n, BASE_LAT + 2550); end
    total++; if (wr_cnt - base != 256) begin bad++; $display("FAIL max_count got=%0d exp=256", wr_cnt - base); end
    aerr = 0; derr = 0;
    for (int m = 0; m < 256; m++) begin
      idx = 12'(base + m);
      exp = m == 0 ? 8'd255 : ct_mem[m] ^ ref_ks[m];
      if (wr_adr[idx] !== 8'(m)) aerr++;
      if (wr_dat[idx] !== exp) derr++;
    end
    total++; if (aerr != 0) begin bad++; $display("FAIL max_addr_order got=%0d wrong exp=0", aerr); end
    total++; if (derr != 0) begin bad++; $display("FAIL max_data got=%0d wrong exp=0 key=%h", derr, k); end
  endtask

  initial begin
    for (int m = 0; m < 256; m++) ct_mem[m] = 8'd0;
    test_reset;
    test_idle;
    test_empty;
    test_init_ksa;
    test_known_answer;
    test_busy_restart;
    test_max_length;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
